// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: bus widths and packed field layouts shared by the
// memory stage and its neighbours (execute, write-back, decode bypass).
package mem_stage_pkg;

   localparam int ES_TO_MS_BUS_WD   = 71;
   localparam int MS_TO_WS_BUS_WD   = 70;
   localparam int MS_FWD_BLK_BUS_WD = 38;

   // {res_from_mem, gr_we, dest, alu_result, pc}
   typedef struct packed {
      logic        res_from_mem;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] alu_result;
      logic [31:0] pc;
   } es_to_ms_t;

   // {gr_we, dest, final_result, pc}
   typedef struct packed {
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] final_result;
      logic [31:0] pc;
   } ms_to_ws_t;

   // {rf_wen, rf_dest, rf_wdata}
   typedef struct packed {
      logic        rf_wen;
      logic [4:0]  rf_dest;
      logic [31:0] rf_wdata;
   } ms_fwd_t;

endpackage

// File: rtl/ms_rdata_hold.sv
// ms_rdata_hold: captures SRAM read data in a load's first cycle when
// write-back stalls. Ports: clk, reset, ms_valid, is_load, ws_allowin,
// enter, rdata in; data_out = hold_valid ? hold_data : rdata.
// Built only when MS_RDATA_HOLD_EN is defined.
`ifdef MS_RDATA_HOLD_EN
module ms_rdata_hold (
   input  logic        clk,
   input  logic        reset,
   input  logic        ms_valid,
   input  logic        is_load,
   input  logic        ws_allowin,
   input  logic        enter,
   input  logic [31:0] rdata,
   output logic [31:0] data_out
);

   logic        hold_valid;
   logic [31:0] hold_data;
   logic        set_hold;
   logic        clr_hold;

   assign set_hold = ms_valid && is_load && !hold_valid && !ws_allowin;
   assign clr_hold = (ms_valid && ws_allowin) || enter;

   // clear wins so a leave/enter edge never inherits stale data
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_valid <= 1'b0;
         hold_data  <= 32'h0;
      end else if (clr_hold) begin
         hold_valid <= 1'b0;
      end else if (set_hold) begin
         hold_valid <= 1'b1;
         hold_data  <= rdata;
      end
   end

   assign data_out = hold_valid ? hold_data : rdata;

endmodule
`endif

// File: rtl/mem_stage.sv
// mem_stage: registers the execute bus, merges SRAM load data into the
// result, offers it to write-back and bypasses it to decode.
// Ports: clk, reset, ws_allowin, ms_allowin, es_to_ms_valid/bus,
// ms_to_ws_valid/bus, data_sram_rdata, ms_fwd_blk_bus.
// Option MS_RDATA_HOLD_EN: keep load data stable under write-back stall.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         ws_allowin,
   output logic                         ms_allowin,
   input  logic                         es_to_ms_valid,
   input  logic [ES_TO_MS_BUS_WD-1:0]   es_to_ms_bus,
   output logic                         ms_to_ws_valid,
   output logic [MS_TO_WS_BUS_WD-1:0]   ms_to_ws_bus,
   input  logic [31:0]                  data_sram_rdata,
   output logic [MS_FWD_BLK_BUS_WD-1:0] ms_fwd_blk_bus
);

   es_to_ms_t   ms_r;
   ms_to_ws_t   ws_out;
   ms_fwd_t     fwd;
   logic        ms_valid;
   logic        ms_ready_go;
   logic        ms_enter;
   logic [31:0] ld_data;
   logic [31:0] final_result;

   assign ms_ready_go    = 1'b1;
   assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
   assign ms_to_ws_valid = ms_valid && ms_ready_go;
   assign ms_enter       = es_to_ms_valid && ms_allowin;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ms_valid <= 1'b0;
      end else if (ms_allowin) begin
         ms_valid <= es_to_ms_valid;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ms_r <= '0;
      end else if (ms_enter) begin
         ms_r <= es_to_ms_t'(es_to_ms_bus);
      end
   end

`ifdef MS_RDATA_HOLD_EN
   ms_rdata_hold u_hold (
      .clk        (clk),
      .reset      (reset),
      .ms_valid   (ms_valid),
      .is_load    (ms_r.res_from_mem),
      .ws_allowin (ws_allowin),
      .enter      (ms_enter),
      .rdata      (data_sram_rdata),
      .data_out   (ld_data)
   );
`else
   assign ld_data = data_sram_rdata;
`endif

   assign final_result = ms_r.res_from_mem ? ld_data : ms_r.alu_result;

   always_comb begin
      ws_out              = '0;
      ws_out.gr_we        = ms_r.gr_we;
      ws_out.dest         = ms_r.dest;
      ws_out.final_result = final_result;
      ws_out.pc           = ms_r.pc;
   end

   // load data is already resolved here, so decode never blocks on us
   always_comb begin
      fwd          = '0;
      fwd.rf_wen   = ms_valid && ms_r.gr_we;
      fwd.rf_dest  = ms_r.dest;
      fwd.rf_wdata = final_result;
   end

   assign ms_to_ws_bus   = ws_out;
   assign ms_fwd_blk_bus = fwd;

endmodule
